// File: rtl/vending_pkg.sv
// Shared vending-machine definitions: keypad FSM states, row reset pattern,
// and key code constants for the 4x4 keypad layout (code = row*4 + column).
package vending_pkg;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HOLD,
    ST_RELEASE
  } kp_state_t;

  localparam logic [3:0] ROW_RESET = 4'b1110;

  // Layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
  localparam logic [3:0] KEY_1 = 4'h0;
  localparam logic [3:0] KEY_2 = 4'h1;
  localparam logic [3:0] KEY_3 = 4'h2;
  localparam logic [3:0] KEY_A = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_B = 4'h7;
  localparam logic [3:0] KEY_7 = 4'h8;
  localparam logic [3:0] KEY_8 = 4'h9;
  localparam logic [3:0] KEY_9 = 4'hA;
  localparam logic [3:0] KEY_C = 4'hB;
  localparam logic [3:0] KEY_CANCEL = 4'hC;
  localparam logic [3:0] KEY_0 = 4'hD;
  localparam logic [3:0] KEY_ENTER = 4'hE;
  localparam logic [3:0] KEY_D = 4'hF;

  function automatic logic key_is_digit(input logic [3:0] code);
    return (code[1:0] != 2'd3) && (code != KEY_CANCEL) && (code != KEY_ENTER);
  endfunction

  // BCD value of a digit key; non-digit keys return 4'hF.
  function automatic logic [3:0] key_digit(input logic [3:0] code);
    logic [3:0] d;
    d = 4'hF;
    if (code == KEY_0) begin
      d = 4'd0;
    end else if (key_is_digit(code)) begin
      d = 4'(code[3:2] * 2'd3 + code[1:0] + 1'd1);
    end
    return d;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; flops reset to all-ones
// so idle (pulled-up) lines read as inactive out of reset.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad front end: row scan on a free-running divider tick,
// press/release debounce, and one key code per press over valid/ack.
module keypad_scanner
  import vending_pkg::*;
#(
  parameter int SCAN_DIV       = 13,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack
);

  localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_SCANS);

  logic [SCAN_DIV-1:0] r_div;
  logic                w_tick;
  logic [3:0]          w_cols;
  logic                w_pressed;
  logic [1:0]          w_col_idx;
  logic [3:0]          w_code;
  logic [3:0]          w_cnt_inc;
  logic                w_accept;

  kp_state_t  r_state;
  logic [1:0] r_row_idx;
  logic [3:0] r_row;
  logic [3:0] r_cand;
  logic [3:0] r_cnt;
  logic [3:0] r_key_code;
  logic       r_key_valid;

  sync_2ff #(.WIDTH(4)) u_col_sync (
    .clk (clk),
    .clr (clr),
    .i_d (col),
    .o_q (w_cols)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_div <= '0;
    else     r_div <= r_div + 1'b1;
  end

  assign w_tick    = &r_div;
  assign w_pressed = ~&w_cols;

  // Lowest-numbered low column wins when several keys share the row.
  always_comb begin
    w_col_idx = 2'd0;
    if (!w_cols[0])      w_col_idx = 2'd0;
    else if (!w_cols[1]) w_col_idx = 2'd1;
    else if (!w_cols[2]) w_col_idx = 2'd2;
    else if (!w_cols[3]) w_col_idx = 2'd3;
  end

  assign w_code    = {r_row_idx, w_col_idx};
  assign w_cnt_inc = r_cnt + 4'd1;
  assign w_accept  = w_tick && (r_state == ST_DEBOUNCE) && w_pressed &&
                     (w_code == r_cand) && (w_cnt_inc == DB_LAST);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state     <= ST_SCAN;
      r_row_idx   <= 2'd0;
      r_row       <= ROW_RESET;
      r_cand      <= '0;
      r_cnt       <= '0;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
    end else begin
      // A fresh accept takes priority over an ack landing in the same cycle.
      if (w_accept) begin
        r_key_code  <= r_cand;
        r_key_valid <= 1'b1;
      end else if (key_ack) begin
        r_key_valid <= 1'b0;
      end

      if (w_tick) begin
        case (r_state)
          ST_SCAN: begin
            if (w_pressed) begin
              r_cand  <= w_code;
              r_cnt   <= 4'd1;
              r_state <= ST_DEBOUNCE;
            end else begin
              r_row_idx <= r_row_idx + 2'd1;
              r_row     <= {r_row[2:0], r_row[3]};
            end
          end
          ST_DEBOUNCE: begin
            if (w_pressed && (w_code == r_cand)) begin
              r_cnt <= w_cnt_inc;
              if (w_cnt_inc == DB_LAST) r_state <= ST_HOLD;
            end else begin
              r_cnt     <= '0;
              r_row_idx <= r_row_idx + 2'd1;
              r_row     <= {r_row[2:0], r_row[3]};
              r_state   <= ST_SCAN;
            end
          end
          ST_HOLD: begin
            if (!w_pressed) begin
              r_cnt   <= 4'd1;
              r_state <= ST_RELEASE;
            end
          end
          ST_RELEASE: begin
            if (w_pressed) begin
              r_cnt   <= '0;
              r_state <= ST_HOLD;
            end else if (w_cnt_inc == DB_LAST) begin
              r_cnt     <= '0;
              r_row_idx <= r_row_idx + 2'd1;
              r_row     <= {r_row[2:0], r_row[3]};
              r_state   <= ST_SCAN;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          default: r_state <= ST_SCAN;
        endcase
      end
    end
  end

  assign row       = r_row;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a combinational keypad model
// (one key pulls its column low while its row is driven).
module tb_keypad_scanner;

  logic       clk;
  logic       clr;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;

  logic       key_on;
  logic [3:0] key_row;
  logic [3:0] key_mask;
  logic [3:0] tb_div;

  int errors;
  int checks;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(4)) dut (
    .clk       (clk),
    .clr       (clr),
    .col       (col),
    .row       (row),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ack   (key_ack)
  );

  assign col = (key_on && (row == key_row)) ? key_mask : 4'hF;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bench-side copy of the scan divider, used only to find tick edges.
  always @(posedge clk or posedge clr) begin
    if (clr) tb_div <= 4'd0;
    else     tb_div <= tb_div + 4'd1;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic next_tick();
    do @(negedge clk); while (tb_div != 4'd15);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_row(input logic [3:0] pat);
    for (int i = 0; i < 8 && row !== pat; i++) next_tick();
    checks++;
    if (row !== pat) begin
      errors++;
      $display("FAIL wait_row: row=%b want=%b", row, pat);
    end
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    key_ack = 1'b1;
    @(posedge clk);
    #1;
    key_ack = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_rows [8];
    exp_rows = '{4'b1101, 4'b1011, 4'b0111, 4'b1110,
                 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (row !== 4'b1110 || key_valid !== 1'b0 || key_code !== 4'h0) begin
      errors++;
      $display("FAIL reset_values: row=%b valid=%b code=%h want 1110/0/0", row, key_valid, key_code);
    end
    @(negedge clk);
    clr = 1'b0;
    for (int t = 0; t < 8; t++) begin
      next_tick();
      checks++;
      if (row !== exp_rows[t] || key_valid !== 1'b0 || key_code !== 4'h0) begin
        errors++;
        $display("FAIL idle_scan[%0d]: row=%b valid=%b code=%h want %b/0/0",
                 t, row, key_valid, key_code, exp_rows[t]);
      end
    end
  endtask

  task automatic test_clean_press();
    wait_row(4'b1011);
    key_row = 4'b1011; key_mask = 4'b1101; key_on = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      next_tick();
      checks++;
      if (key_valid !== 1'b0 || row !== 4'b1011) begin
        errors++;
        $display("FAIL clean_debounce[%0d]: valid=%b row=%b want 0/1011", t, key_valid, row);
      end
    end
    do @(negedge clk); while (tb_div != 4'd15);
    checks++;
    if (key_valid !== 1'b0) begin
      errors++;
      $display("FAIL clean_early: valid=%b want 0 before 4th tick", key_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (key_valid !== 1'b1 || key_code !== 4'h9) begin
      errors++;
      $display("FAIL clean_accept: valid=%b code=%h want 1/9", key_valid, key_code);
    end
    ack_pulse();
    checks++;
    if (key_valid !== 1'b0 || key_code !== 4'h9) begin
      errors++;
      $display("FAIL clean_ack: valid=%b code=%h want 0/9", key_valid, key_code);
    end
    key_on = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      next_tick();
      checks++;
      if (row !== ((t < 4) ? 4'b1011 : 4'b0111)) begin
        errors++;
        $display("FAIL clean_release[%0d]: row=%b", t, row);
      end
    end
  endtask

  task automatic test_bounce();
    key_on = 1'b0;
    wait_row(4'b1011);
    key_row = 4'b1011; key_mask = 4'b1101;
    for (int t = 0; t < 16; t++) begin
      key_on = ((t % 2) == 0);
      next_tick();
      checks++;
      if (key_valid !== 1'b0) begin
        errors++;
        $display("FAIL bounce_valid[%0d]: valid=%b want 0", t, key_valid);
      end
    end
    key_on = 1'b0;
    checks++;
    if (row !== 4'b1101) begin
      errors++;
      $display("FAIL bounce_resume: row=%b want 1101", row);
    end
  endtask

  task automatic test_held_key();
    logic exp_v;
    key_on = 1'b0;
    wait_row(4'b1110);
    key_row = 4'b1110; key_mask = 4'b1110; key_on = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      next_tick();
      exp_v = (t >= 4) && (t <= 10);
      checks++;
      if (key_valid !== exp_v || row !== 4'b1110) begin
        errors++;
        $display("FAIL held[%0d]: valid=%b row=%b want %b/1110", t, key_valid, row, exp_v);
      end
      if (t == 10) ack_pulse();
    end
    checks++;
    if (key_code !== 4'h0) begin
      errors++;
      $display("FAIL held_code: code=%h want 0", key_code);
    end
    key_on = 1'b0;
    repeat (3) next_tick();
    key_on = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      next_tick();
      checks++;
      if (key_valid !== 1'b0 || row !== 4'b1110) begin
        errors++;
        $display("FAIL held_repress[%0d]: valid=%b row=%b want 0/1110", t, key_valid, row);
      end
    end
    key_on = 1'b0;
    repeat (4) next_tick();
    checks++;
    if (row !== 4'b1101 || key_valid !== 1'b0) begin
      errors++;
      $display("FAIL held_release: row=%b valid=%b want 1101/0", row, key_valid);
    end
    wait_row(4'b1110);
    key_on = 1'b1;
    repeat (4) next_tick();
    checks++;
    if (key_valid !== 1'b1 || key_code !== 4'h0) begin
      errors++;
      $display("FAIL held_fresh: valid=%b code=%h want 1/0", key_valid, key_code);
    end
    ack_pulse();
    key_on = 1'b0;
    repeat (4) next_tick();
  endtask

  task automatic test_multi_and_overwrite();
    wait_row(4'b0111);
    key_row = 4'b0111; key_mask = 4'b1001; key_on = 1'b1;
    repeat (4) next_tick();
    checks++;
    if (key_valid !== 1'b1 || key_code !== 4'hD) begin
      errors++;
      $display("FAIL multi_press: valid=%b code=%h want 1/d", key_valid, key_code);
    end
    key_on = 1'b0;
    repeat (4) next_tick();
    checks++;
    if (row !== 4'b1110 || key_valid !== 1'b1 || key_code !== 4'hD) begin
      errors++;
      $display("FAIL multi_release: row=%b valid=%b code=%h want 1110/1/d", row, key_valid, key_code);
    end
    key_row = 4'b1110; key_mask = 4'b0111; key_on = 1'b1;
    repeat (3) next_tick();
    checks++;
    if (key_valid !== 1'b1 || key_code !== 4'hD) begin
      errors++;
      $display("FAIL overwrite_hold: valid=%b code=%h want 1/d", key_valid, key_code);
    end
    do @(negedge clk); while (tb_div != 4'd15);
    key_ack = 1'b1;
    @(posedge clk);
    #1;
    key_ack = 1'b0;
    checks++;
    if (key_valid !== 1'b1 || key_code !== 4'h3) begin
      errors++;
      $display("FAIL overwrite_accept: valid=%b code=%h want 1/3", key_valid, key_code);
    end
    ack_pulse();
    checks++;
    if (key_valid !== 1'b0) begin
      errors++;
      $display("FAIL overwrite_ack: valid=%b want 0", key_valid);
    end
    ack_pulse();
    checks++;
    if (key_valid !== 1'b0 || key_code !== 4'h3) begin
      errors++;
      $display("FAIL idle_ack: valid=%b code=%h want 0/3", key_valid, key_code);
    end
    key_on = 1'b0;
    repeat (4) next_tick();
  endtask

  task automatic test_clr_in_hold();
    wait_row(4'b1101);
    key_row = 4'b1101; key_mask = 4'b1011; key_on = 1'b1;
    repeat (4) next_tick();
    checks++;
    if (key_valid !== 1'b1 || key_code !== 4'h6) begin
      errors++;
      $display("FAIL clr_pre: valid=%b code=%h want 1/6", key_valid, key_code);
    end
    @(negedge clk);
    clr = 1'b1;
    #1;
    checks++;
    if (key_valid !== 1'b0 || row !== 4'b1110 || key_code !== 4'h0) begin
      errors++;
      $display("FAIL clr_async: valid=%b row=%b code=%h want 0/1110/0", key_valid, row, key_code);
    end
    @(negedge clk);
    clr = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      next_tick();
      checks++;
      if (key_valid !== (t == 5) || row !== 4'b1101 ||
          (t == 5 && key_code !== 4'h6)) begin
        errors++;
        $display("FAIL clr_redebounce[%0d]: valid=%b row=%b code=%h", t, key_valid, row, key_code);
      end
    end
    key_on = 1'b0;
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    clr      = 1'b1;
    key_ack  = 1'b0;
    key_on   = 1'b0;
    key_row  = 4'hF;
    key_mask = 4'hF;
    test_reset();
    test_clean_press();
    test_bounce();
    test_held_key();
    test_multi_and_overwrite();
    test_clr_in_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
